// File: rtl/block_reg_file_pkg.sv
// Shared constants for the general-purpose register bank and its storage cells.
package block_reg_file_pkg;

  localparam int DEF_SIZE_ADDR_REG = 5;
  localparam int DEF_SIZE_REG      = 8;
  localparam int DEF_NREG          = 2 ** DEF_SIZE_ADDR_REG;

endpackage

// File: rtl/block_reg_file_reg_cell.sv
// One storage word of the register bank: load-enabled register with async clear.
module reg_cell
  import block_reg_file_pkg::*;
#(
  parameter int SIZE_REG = DEF_SIZE_REG
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [SIZE_REG-1:0] d,
  output logic [SIZE_REG-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/block_reg_file.sv
// CPU register file: one clocked write port, two combinational read ports, no bypass.
module block_reg_file
  import block_reg_file_pkg::*;
#(
  parameter int SIZE_ADDR_REG = DEF_SIZE_ADDR_REG,
  parameter int SIZE_REG      = DEF_SIZE_REG
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     charge,
  input  logic [SIZE_ADDR_REG-1:0] addr_write_reg,
  input  logic [SIZE_ADDR_REG-1:0] outA,
  input  logic [SIZE_ADDR_REG-1:0] outB,
  input  logic [SIZE_REG-1:0]      datain,
  output logic [SIZE_REG-1:0]      dataoutA,
  output logic [SIZE_REG-1:0]      dataoutB
);

  localparam int NREG = 2 ** SIZE_ADDR_REG;

  logic [NREG-1:0]     load;
  logic [SIZE_REG-1:0] reg_q [NREG];

  // One-hot write decode; each cell loads only when it is the addressed target.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_cell
    assign load[gi] = charge && (addr_write_reg == SIZE_ADDR_REG'(gi));

    reg_cell #(
      .SIZE_REG(SIZE_REG)
    ) u_cell (
      .clk  (clk),
      .reset(reset),
      .load (load[gi]),
      .d    (datain),
      .q    (reg_q[gi])
    );
  end

  // Address width covers exactly NREG entries, so every index is in range.
  assign dataoutA = reg_q[outA];
  assign dataoutB = reg_q[outB];

endmodule

// File: tb/tb_block_reg_file.sv
// Randomized self-checking bench for block_reg_file against an array reference model.
module tb_block_reg_file;

  localparam int AW   = 5;
  localparam int DW   = 8;
  localparam int NREG = 2 ** AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          charge;
  logic [AW-1:0] addr_write_reg;
  logic [AW-1:0] outA;
  logic [AW-1:0] outB;
  logic [DW-1:0] datain;
  logic [DW-1:0] dataoutA;
  logic [DW-1:0] dataoutB;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            model [NREG];

  block_reg_file #(
    .SIZE_ADDR_REG(AW),
    .SIZE_REG     (DW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .charge        (charge),
    .addr_write_reg(addr_write_reg),
    .outA          (outA),
    .outB          (outB),
    .datain        (datain),
    .dataoutA      (dataoutA),
    .dataoutB      (dataoutB)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [DW-1:0] got, input int exp);
    n_cmp++;
    if (got !== DW'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reads(input string tag);
    check_value({tag, "_A"}, dataoutA, model[outA]);
    check_value({tag, "_B"}, dataoutB, model[outB]);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NREG; i++) model[i] = 0;
  endtask

  initial begin
    reset = 1'b1; charge = 1'b0; addr_write_reg = '0;
    outA = '0; outB = '0; datain = '0;
    clear_model();
    #2;
    check_value("reset_A", dataoutA, 0);
    check_value("reset_B", dataoutB, 0);
    @(negedge clk);
    reset = 1'b0;

    // Write 7 to reg 2: invisible while clk is low, visible after the edge.
    @(negedge clk);
    charge = 1'b1; addr_write_reg = 5'd2; datain = 8'd7; outA = 5'd2;
    #1 check_value("prewrite_r2", dataoutA, 0);
    @(posedge clk); model[2] = 7;
    #1 check_value("write7_r2", dataoutA, 7);
    $display("txn write r2=7 read A=%0d", dataoutA);

    // Data changes while clk is high must not write.
    datain = 8'd0;
    #2 check_value("clkhigh_r2", dataoutA, 7);
    @(negedge clk);
    charge = 1'b0;
    #1 check_value("clklow_r2", dataoutA, 7);
    @(posedge clk);
    #1 check_value("nocharge_r2", dataoutA, 7);
    $display("txn no-write checks read A=%0d", dataoutA);

    // Overwrite, then high-address write with both ports active.
    @(negedge clk);
    charge = 1'b1; addr_write_reg = 5'd2; datain = 8'd250;
    @(posedge clk); model[2] = 250;
    #1 check_value("overwrite_r2", dataoutA, 250);
    @(negedge clk);
    addr_write_reg = 5'd30; datain = 8'd124; outB = 5'd30; outA = 5'd2;
    @(posedge clk); model[30] = 124;
    #1 check_value("dual_B_r30", dataoutB, 124);
    check_value("dual_A_r2", dataoutA, 250);
    $display("txn write r30=124 read A=%0d B=%0d", dataoutA, dataoutB);

    // Sweep: each register gets i+1; expectations come from the index, not the model.
    for (int i = 0; i < NREG; i++) begin
      @(negedge clk);
      charge = 1'b1; addr_write_reg = AW'(i); datain = DW'(i + 1);
      @(posedge clk); model[i] = i + 1;
    end
    @(negedge clk);
    charge = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      outA = AW'(i); outB = AW'(NREG - 1 - i);
      #1;
      check_value("sweep_A", dataoutA, i + 1);
      check_value("sweep_B", dataoutB, NREG - i);
    end
    $display("txn sweep of %0d registers read back", NREG);

    // Async reset after writes, held across an edge with charge asserted.
    @(negedge clk);
    outA = 5'd5; outB = 5'd31;
    charge = 1'b1; addr_write_reg = 5'd5; datain = 8'hAA;
    #1 reset = 1'b1;
    #1;
    clear_model();
    check_value("async_rst_A", dataoutA, 0);
    check_value("async_rst_B", dataoutB, 0);
    @(posedge clk);
    #1 check_value("rst_dominates", dataoutA, 0);
    @(negedge clk);
    reset = 1'b0; charge = 1'b0;
    $display("txn async reset clears bank");

    // Randomized traffic with occasional mid-cycle async reset.
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      charge         = 1'($urandom_range(0, 1));
      addr_write_reg = AW'($urandom_range(0, NREG - 1));
      datain         = DW'($urandom);
      outA           = ($urandom_range(0, 3) == 0) ? addr_write_reg : AW'($urandom_range(0, NREG - 1));
      outB           = AW'($urandom_range(0, NREG - 1));
      #1 check_reads("rand_pre");
      if ($urandom_range(0, 24) == 0) begin
        reset = 1'b1;
        #1 clear_model();
        check_reads("rand_rst");
        #1 reset = 1'b0;
      end
      @(posedge clk);
      if (charge) model[addr_write_reg] = int'(datain);
      #1 check_reads("rand_post");
      $display("txn %0d we=%0d wa=%0d wd=%0d ra=%0d A=%0d rb=%0d B=%0d",
               t, charge, addr_write_reg, datain, outA, dataoutA, outB, dataoutB);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/block_reg_file.md
Name:
block_reg_file

Overview:
- Multi-ported register bank: 2**SIZE_ADDR_REG registers, each SIZE_REG bits wide.
- One synchronous write port (load-enabled) and two independent combinational read ports (A and B).
- Sits in the datapath as the CPU general-purpose register file; the execute stage reads operands on A/B and writeback drives the write port.

Parameters:
- SIZE_ADDR_REG, 5, register address width; register count NREG = 2**SIZE_ADDR_REG (32).
- SIZE_REG, 8, data width of each register and of all data ports.

Ports:
- clk  input  1  single clock; writes occur on the rising edge.
- reset  input  1  asynchronous, active-high; clears every register.
- charge  input  1  write enable (load); sampled on the clk rising edge.
- addr_write_reg  input  SIZE_ADDR_REG  index of the register written.
- outA  input  SIZE_ADDR_REG  read address, port A.
- outB  input  SIZE_ADDR_REG  read address, port B.
- datain  input  SIZE_REG  write data.
- dataoutA  output  SIZE_REG  contents of register[outA].
- dataoutB  output  SIZE_REG  contents of register[outB].

Behaviour:
- Reset:
  - reset=1 immediately forces all NREG registers to 0, independent of clk; dataoutA/dataoutB read 0.
  - Reset dominates charge; while reset is high no write takes effect.
- Write:
  - On posedge clk with reset=0 and charge=1: register[addr_write_reg] <= datain.
  - Only the addressed register changes; all others hold.
  - charge=0 at the edge: no register changes.
  - Any changes to charge, address or data while clk is stable (high or low) have no effect; only the edge samples.
- Read:
  - Purely combinational, zero latency: dataoutA = register[outA], dataoutB = register[outB].
  - Outputs follow address changes without a clock.
  - Both ports may address the same register, and the write register, simultaneously.
- Read-during-write: before the edge, outputs show the old value; the new value appears immediately after the write edge. There is no write-through bypass.
- All registers, including index 0, are ordinary writable storage; none is hardwired to zero.
- All addresses in 0..NREG-1 are valid; there is no out-of-range case.
- Registers hold their value indefinitely between writes.

Decomposition:
- Shared package: default constants SIZE_ADDR_REG=5 and SIZE_REG=8, plus derived NREG.
- One natural sub-module, reg_cell: a SIZE_REG-bit register with async active-high clear and a load enable.
- The top level contains:
  - an address decoder producing the per-register load, equal to charge & (addr_write_reg==i);
  - a generate array of NREG reg_cell instances;
  - two NREG:1 read multiplexers.

Test Plan:
- Reset: reset=1, outA=outB=0 → dataoutA=dataoutB=0. Assert reset after writes → all outputs read 0 immediately, without a clock edge.
- Write 7 to register 2: charge=1, addr_write_reg=2, datain=7, outA=2, clk held low → dataoutA stays 0. Then clk rises → dataoutA=7.
- No-write cases, each of which must leave reg2 at 7:
  - charge=0 with a clk edge;
  - charge=1 while clk is held low;
  - addr_write_reg=2, datain=0 raised while clk is already high, with no new edge.
- Overwrite: clk low, then rising edge with charge=1, addr_write_reg=2, datain=250 → dataoutA=250.
- Dual-port, high address: write 124 to register 30 with outB=30, outA=2 → dataoutB=124 and dataoutA=250 simultaneously.
- Sweep: write i+1 into every register 0..31, then read all addresses on both ports → each returns i+1, with no aliasing.
